lcd_spi_master: RTL and testbench

//  Parametrised SPI transmit master for the LCD panel path; successor to the fixed 8-bit/mode-3 sender.

---
 rtl/lcd_spi_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lcd_spi_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_master.sv
// lcd_spi_master
//   SPI transmit master for the LCD panel path. Words {dc, last, data} arrive
//   on a valid/ready stream, are buffered, then shifted out MSB first with a
//   configurable SCLK divider and CPOL/CPHA. CS stays low across words until
//   a word flagged "last" has been sent, followed by a minimum deselect gap.
//
//   Optional feature macro: LCD_SPI_FIFO_EN
//     defined   : FIFO_DEPTH-entry synchronous FIFO input buffer
//     undefined : single holding register (refills while the shifter runs)
//
// Ports
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   valid_i  input word valid
//   ready_o  buffer can accept (registered, = not full)
//   data_i   word to send, MSB first
//   dc_i     data/command flag carried with the word
//   last_i   release CS after this word
//   sclk_o   SPI clock (idles at CPOL)
//   sda_o    SPI data
//   dc_o     data/command line, updated when a word is loaded
//   cs_no    chip select, active low
//   busy_o   buffer non-empty, shifter active or CS low
//   level_o  number of buffered words
module lcd_spi_master #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 2,
    parameter int CPOL       = 1,
    parameter int CPHA       = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        dc_i,
    input  logic                        last_i,
    output logic                        sclk_o,
    output logic                        sda_o,
    output logic                        dc_o,
    output logic                        cs_no,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = DATA_W + 2;
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int EDG_W = $clog2(2 * DATA_W) + 1;
    localparam logic [CNT_W-1:0] DIV_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [EDG_W-1:0] LAST_EDGE = EDG_W'(2 * DATA_W - 1);
    localparam logic             SCLK_IDLE = 1'(CPOL);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, TAIL, GAP} state_t;

    logic             push;
    logic             pop;
    logic             head_vld;
    logic [ENT_W-1:0] head;
    logic [LVL_W-1:0] level;
    logic             ready_q;

    assign push     = valid_i && ready_q;
    assign ready_o  = ready_q;
    assign level_o  = level;
    assign head_vld = (level != '0);

`ifdef LCD_SPI_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level_n;

    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + LVL_W'(1);
        else if (pop && !push)
            level_n = level - LVL_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= {dc_i, last_i, data_i};
    end

    // ready is derived from the next level, so a full buffer keeps ready low
    // in the cycle of a simultaneous pop and reopens one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level   <= level_n;
            ready_q <= (level_n != LVL_W'(FIFO_DEPTH));
        end
    end

    assign head = mem[rd_ptr];
`else
    logic [ENT_W-1:0] hold_q;
    logic             hold_vld;
    logic             hold_vld_n;

    // push and pop are exclusive here: ready is only high while empty.
    always_comb begin
        hold_vld_n = hold_vld;
        if (push)
            hold_vld_n = 1'b1;
        else if (pop)
            hold_vld_n = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push)
            hold_q <= {dc_i, last_i, data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            hold_vld <= hold_vld_n;
            ready_q  <= !hold_vld_n;
        end
    end

    assign head  = hold_q;
    assign level = {{(LVL_W-1){1'b0}}, hold_vld};
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [EDG_W-1:0]  edge_cnt, edge_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              sclk_q, sclk_n;
    logic              sda_q, sda_n;
    logic              dc_q, dc_n;
    logic              cs_q, cs_n;
    logic              last_q, last_n;
    logic              tick;
    logic              load;

    assign tick = (cnt == DIV_MAX);
    assign pop  = load;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        edge_n  = edge_cnt;
        sh_n    = sh;
        sclk_n  = sclk_q;
        sda_n   = sda_q;
        dc_n    = dc_q;
        cs_n    = cs_q;
        last_n  = last_q;
        load    = 1'b0;

        // Half-period divider runs only in the timed states.
        if (state != IDLE && state != HOLD && !tick)
            cnt_n = cnt + CNT_W'(1);

        case (state)
            IDLE, HOLD: load = head_vld;
            SETUP: begin
                if (tick) begin
                    state_n = SHIFT;
                    edge_n  = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_n = ~sclk_q;
                    edge_n = edge_cnt + EDG_W'(1);
                    // Even edge index = leading edge. CPHA=0 already put the
                    // MSB out at load and skips the final trailing edge so the
                    // LSB stays on the line.
                    if ((CPHA != 0) ? !edge_cnt[0]
                                    : (edge_cnt[0] && edge_cnt != LAST_EDGE)) begin
                        sda_n = sh[DATA_W-1];
                        sh_n  = sh << 1;
                    end
                    if (edge_cnt == LAST_EDGE) begin
                        if (last_q)
                            state_n = TAIL;
                        else if (head_vld)
                            load = 1'b1;
                        else
                            state_n = HOLD;
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    cs_n    = 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (tick)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            state_n = SETUP;
            dc_n    = head[ENT_W-1];
            last_n  = head[ENT_W-2];
            cs_n    = 1'b0;
            if (CPHA == 0) begin
                sda_n = head[DATA_W-1];
                sh_n  = head[DATA_W-1:0] << 1;
            end else begin
                sh_n  = head[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        sh <= sh_n;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            sclk_q   <= SCLK_IDLE;
            sda_q    <= 1'b0;
            dc_q     <= 1'b0;
            cs_q     <= 1'b1;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            edge_cnt <= edge_n;
            sclk_q   <= sclk_n;
            sda_q    <= sda_n;
            dc_q     <= dc_n;
            cs_q     <= cs_n;
            last_q   <= last_n;
        end
    end

    assign sclk_o = sclk_q;
    assign sda_o  = sda_q;
    assign dc_o   = dc_q;
    assign cs_no  = cs_q;
    assign busy_o = head_vld || (state != IDLE) || !cs_q;

endmodule

// File: tb/tb_lcd_spi_master.sv
`timescale 1ns/1ps
module tb_lcd_spi_master;
`ifdef LCD_SPI_FIFO_EN
    localparam int DEPTH_EXP = 16;
`else
    localparam int DEPTH_EXP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: mode 3, 8-bit words, CLK_DIV=2
    logic       valid = 1'b0, dc = 1'b0, last = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, sclk, sda, dc_pin, cs_n, busy;
    logic [4:0] level;

    lcd_spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .FIFO_DEPTH(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready), .data_i(data),
        .dc_i(dc), .last_i(last), .sclk_o(sclk), .sda_o(sda), .dc_o(dc_pin),
        .cs_no(cs_n), .busy_o(busy), .level_o(level)
    );

    // Four mode-sweep DUTs, CLK_DIV=1, index m = {CPOL, CPHA}
    logic       sw_valid = 1'b0;
    logic [7:0] sw_data = 8'h00;
    logic [3:0] sw_ready, sw_sclk, sw_sda, sw_dc, sw_cs, sw_busy;
    logic [4:0] sw_level [4];
    wire  [31:0] sw_rx_all;
    wire  [31:0] sw_nb_all;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int P_CPOL = m / 2;
        localparam int P_CPHA = m % 2;
        logic       smp;
        logic [7:0] rx = 8'h00;
        int         nb = 0;
        // sample on rising edge when CPOL==CPHA, falling edge otherwise
        assign smp = sw_sclk[m] ^ ((P_CPOL != P_CPHA) ? 1'b1 : 1'b0);
        lcd_spi_master #(.DATA_W(8), .CLK_DIV(1), .CPOL(P_CPOL), .CPHA(P_CPHA), .FIFO_DEPTH(16)) u_sw (
            .clk_i(clk), .rst_ni(rst_n), .valid_i(sw_valid), .ready_o(sw_ready[m]),
            .data_i(sw_data), .dc_i(1'b1), .last_i(1'b1), .sclk_o(sw_sclk[m]),
            .sda_o(sw_sda[m]), .dc_o(sw_dc[m]), .cs_no(sw_cs[m]), .busy_o(sw_busy[m]),
            .level_o(sw_level[m])
        );
        always @(posedge smp or negedge rst_n) begin
            if (!rst_n) nb = 0;
            else if (!sw_cs[m]) begin
                rx = {rx[6:0], sw_sda[m]};
                nb++;
            end
        end
        assign sw_rx_all[m*8 +: 8] = rx;
        assign sw_nb_all[m*8 +: 8] = nb[7:0];
    end

    // Slave model for the main DUT (mode 3: sample on rising SCLK)
    logic [7:0] rx_sh = 8'h00;
    logic       dc_w = 1'b0;
    int         nb = 0, rises = 0, dc_bad = 0, cs_falls = 0;
    logic [8:0] rx_q [$];
    time        start_q [$], last_rise_q [$], cs_rise_q [$], cs_fall_q [$];

    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) nb = 0;
        else if (!cs_n) begin
            if (nb == 0) begin
                start_q.push_back($time);
                dc_w = dc_pin;
            end else if (dc_pin !== dc_w) dc_bad++;
            rx_sh = {rx_sh[6:0], sda};
            nb++;
            rises++;
            if (nb == 8) begin
                rx_q.push_back({dc_w, rx_sh});
                last_rise_q.push_back($time);
                nb = 0;
            end
        end
    end
    always @(posedge cs_n) if (rst_n) cs_rise_q.push_back($time);
    always @(negedge cs_n) if (rst_n) begin cs_fall_q.push_back($time); cs_falls++; end

    // ready/level invariant monitor for the streaming test
    logic mon_en = 1'b0;
    int   inv_bad = 0, max_lvl = 0;
    always @(negedge clk) if (mon_en) begin
        if (ready !== (level != 5'(DEPTH_EXP))) inv_bad++;
        if (int'(level) > max_lvl) max_lvl = int'(level);
    end

    int n_cmp = 0, n_bad = 0;

    task automatic push_word(input logic [7:0] w, input logic d, input logic l);
        int n = 0;
        valid = 1'b1; data = w; dc = d; last = l;
        while (!ready && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (!ready) begin n_bad++; $display("FAIL push_ready: ready=%0b required 1", ready); end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < limit) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (busy) begin n_bad++; $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, limit); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({sclk, sda, dc_pin, cs_n, busy, ready} !== 6'b100100) begin
            n_bad++; $display("FAIL reset_pins: sclk,sda,dc,cs,busy,ready=%b required 100100", {sclk, sda, dc_pin, cs_n, busy, ready});
        end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level: %0d required 0", level); end
        n_cmp++; if (sw_sclk !== 4'b1100 || sw_cs !== 4'b1111) begin
            n_bad++; $display("FAIL reset_sweep: sclk=%b cs=%b required 1100 1111", sw_sclk, sw_cs);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: %0b required 1", ready); end
    endtask

    task automatic test_single_word();
        int bw = rx_q.size(), br = rises, bcr = cs_rise_q.size(), bcf = cs_fall_q.size();
        push_word(8'h2A, 1'b0, 1'b1);
        push_word(8'h3C, 1'b0, 1'b1);
        wait_idle(200);
        n_cmp++; if (rx_q.size() - bw !== 2) begin n_bad++; $display("FAIL single_count: %0d words required 2", rx_q.size() - bw); end
        else begin
            n_cmp++; if (rx_q[bw] !== 9'h02A) begin n_bad++; $display("FAIL single_word0: %h required 02a", rx_q[bw]); end
            n_cmp++; if (rx_q[bw+1] !== 9'h03C) begin n_bad++; $display("FAIL single_word1: %h required 03c", rx_q[bw+1]); end
            n_cmp++; if (cs_rise_q.size() - bcr < 1 || cs_rise_q[bcr] - last_rise_q[bw] !== 64'd20) begin
                n_bad++; $display("FAIL cs_release_delay: %0d ns required 20", cs_rise_q[bcr] - last_rise_q[bw]);
            end
            n_cmp++; if (cs_fall_q.size() - bcf < 2 || cs_fall_q[bcf+1] - cs_rise_q[bcr] !== 64'd30) begin
                n_bad++; $display("FAIL cs_gap: %0d ns required 30", cs_fall_q[bcf+1] - cs_rise_q[bcr]);
            end
        end
        n_cmp++; if (rises - br !== 16) begin n_bad++; $display("FAIL single_rises: %0d required 16", rises - br); end
        n_cmp++; if (dc_bad !== 0) begin n_bad++; $display("FAIL dc_stable: %0d changes required 0", dc_bad); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [4] = '{9'h100, 9'h100, 9'h100, 9'h1EF};
        int bw = rx_q.size(), br = rises, bf = cs_falls, bs = start_q.size();
        push_word(8'h00, 1'b1, 1'b0);
        push_word(8'h00, 1'b1, 1'b0);
        push_word(8'h00, 1'b1, 1'b0);
        push_word(8'hEF, 1'b1, 1'b1);
        wait_idle(400);
        n_cmp++; if (rx_q.size() - bw !== 4) begin n_bad++; $display("FAIL b2b_count: %0d required 4", rx_q.size() - bw); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rx_q[bw+i] !== exp[i]) begin n_bad++; $display("FAIL b2b_word%0d: %h required %h", i, rx_q[bw+i], exp[i]); end
            if (i > 0) begin
                n_cmp++; if (start_q[bs+i] - start_q[bs+i-1] !== 64'd340) begin
                    n_bad++; $display("FAIL b2b_spacing%0d: %0d ns required 340", i, start_q[bs+i] - start_q[bs+i-1]);
                end
            end
        end
        n_cmp++; if (rises - br !== 32) begin n_bad++; $display("FAIL b2b_rises: %0d required 32", rises - br); end
        n_cmp++; if (cs_falls - bf !== 1) begin n_bad++; $display("FAIL b2b_cs_pulses: %0d required 1", cs_falls - bf); end
        n_cmp++; if (dc_bad !== 0) begin n_bad++; $display("FAIL b2b_dc_stable: %0d required 0", dc_bad); end
    endtask

    task automatic test_hold();
        int bw = rx_q.size(), br = rises, bf = cs_falls, n = 0, bad_hold = 0;
        push_word(8'h55, 1'b0, 1'b0);
        while (rx_q.size() == bw && n < 200) begin @(posedge clk); #1; n++; end
        repeat (50) begin
            @(negedge clk);
            if (cs_n !== 1'b0 || sclk !== 1'b1 || busy !== 1'b1) bad_hold++;
        end
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL hold_static: %0d bad cycles required 0", bad_hold); end
        @(posedge clk); #1;
        push_word(8'hAA, 1'b0, 1'b1);
        wait_idle(200);
        n_cmp++; if (rx_q.size() - bw !== 2) begin n_bad++; $display("FAIL hold_count: %0d required 2", rx_q.size() - bw); end
        else begin
            n_cmp++; if (rx_q[bw] !== 9'h055 || rx_q[bw+1] !== 9'h0AA) begin
                n_bad++; $display("FAIL hold_words: %h %h required 055 0aa", rx_q[bw], rx_q[bw+1]);
            end
        end
        n_cmp++; if (rises - br !== 16 || cs_falls - bf !== 1) begin
            n_bad++; $display("FAIL hold_frame: rises=%0d pulses=%0d required 16 1", rises - br, cs_falls - bf);
        end
    endtask

    task automatic test_mode_sweep();
        int n = 0;
        n_cmp++; if (sw_sclk !== 4'b1100) begin n_bad++; $display("FAIL sweep_idle_pre: %b required 1100", sw_sclk); end
        sw_valid = 1'b1; sw_data = 8'hA5;
        while (!sw_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        sw_valid = 1'b0;
        n = 0;
        @(posedge clk); #1;
        while (sw_busy != 4'b0000 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (sw_busy !== 4'b0000) begin n_bad++; $display("FAIL sweep_timeout: busy=%b required 0000", sw_busy); end
        for (int m = 0; m < 4; m++) begin
            n_cmp++; if (sw_rx_all[m*8 +: 8] !== 8'hA5) begin
                n_bad++; $display("FAIL sweep_data_mode%0d: %h required a5", m, sw_rx_all[m*8 +: 8]);
            end
            n_cmp++; if (sw_nb_all[m*8 +: 8] !== 8'd8) begin
                n_bad++; $display("FAIL sweep_edges_mode%0d: %0d required 8", m, sw_nb_all[m*8 +: 8]);
            end
        end
        n_cmp++; if (sw_sclk !== 4'b1100) begin n_bad++; $display("FAIL sweep_idle_post: %b required 1100", sw_sclk); end
    endtask

    task automatic test_stream();
        logic [8:0] exp [100];
        int bw = rx_q.size(), to_cnt = 0, bad_w = 0;
        mon_en = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int n = 0;
            exp[i] = {1'($urandom), 8'($urandom)};
            dc = exp[i][8]; data = exp[i][7:0]; last = (i == 99);
            while (!ready && n < 200) begin @(posedge clk); #1; n++; end
            if (!ready) to_cnt++;
            @(posedge clk); #1;
        end
        valid = 1'b0; last = 1'b0;
        wait_idle(6000);
        mon_en = 1'b0;
        n_cmp++; if (to_cnt !== 0) begin n_bad++; $display("FAIL stream_ready_timeout: %0d required 0", to_cnt); end
        n_cmp++; if (inv_bad !== 0) begin n_bad++; $display("FAIL stream_ready_vs_level: %0d bad cycles required 0", inv_bad); end
        n_cmp++; if (max_lvl !== DEPTH_EXP) begin n_bad++; $display("FAIL stream_max_level: %0d required %0d", max_lvl, DEPTH_EXP); end
        n_cmp++; if (rx_q.size() - bw !== 100) begin n_bad++; $display("FAIL stream_count: %0d required 100", rx_q.size() - bw); end
        else begin
            for (int i = 0; i < 100; i++) if (rx_q[bw+i] !== exp[i]) bad_w++;
            n_cmp++; if (bad_w !== 0) begin n_bad++; $display("FAIL stream_words: %0d wrong required 0", bad_w); end
        end
    endtask

    task automatic test_reset_abort();
        int n = 0, bw, br;
        push_word(8'h3C, 1'b1, 1'b1);
        while (nb != 3 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL abort_reach_bit3: nb=%0d required 3", nb); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({sclk, sda, dc_pin, cs_n, busy, ready} !== 6'b100100 || level !== 5'd0) begin
            n_bad++; $display("FAIL abort_reset_pins: sclk,sda,dc,cs,busy,ready=%b level=%0d required 100100 0", {sclk, sda, dc_pin, cs_n, busy, ready}, level);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bw = rx_q.size(); br = rises;
        push_word(8'h81, 1'b0, 1'b1);
        wait_idle(200);
        n_cmp++; if (rx_q.size() - bw !== 1) begin n_bad++; $display("FAIL abort_count: %0d required 1", rx_q.size() - bw); end
        else begin
            n_cmp++; if (rx_q[bw] !== 9'h081) begin n_bad++; $display("FAIL abort_word: %h required 081", rx_q[bw]); end
        end
        n_cmp++; if (rises - br !== 8) begin n_bad++; $display("FAIL abort_rises: %0d required 8", rises - br); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold();
        test_mode_sweep();
        test_stream();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
